muldiv_sequencer: RTL and testbench

- Multi-cycle multiply/divide engine and controller for the MIPS datapath.
- Replaces the single-cycle combinational multiplier/divider feeding the HI/LO registers with a radix-2 iterative shift-add / restoring-divide sequence.
- Drives HI/LO write strobes and results, and raises a stall to the control unit while a result is pending.
- Accepts one operation at a time from decode; register-file operands come in on start.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/md_iter_step.sv | 38 +++
 rtl/muldiv_sequencer.sv | 149 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: multiply/divide op codes, sequencer states, widths.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_pkg;

    localparam int MD_OP_WIDTH  = 2;
    localparam int MD_WIDTH     = 32;
    localparam int MD_CNT_WIDTH = $clog2(MD_WIDTH);

    typedef enum logic [MD_OP_WIDTH-1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_PREP,
        MD_RUN,
        MD_FIX,
        MD_DONE
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module md_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] r_sh;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum  = {1'b0, hi[WIDTH-1:0]} + (lo[0] ? {1'b0, m} : '0);
        r_sh = {hi, lo[WIDTH-1]};
        diff = r_sh - {2'b00, m};
        if (is_div) begin
            // remainder stays below the divisor, so the kept value always fits WIDTH+1 bits
            if (!diff[WIDTH+1]) begin
                hi_next = diff[WIDTH:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = r_sh[WIDTH:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next = {1'b0, sum[WIDTH:1]};
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide engine feeding HI/LO, with stall to the control unit.
// Latency: WIDTH+3 cycles from start to the DONE write (2 for divide by zero).
// Backpressure: start ignored while busy; stall held so decode keeps the instruction.
import mips_pkg::*;

module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hilo_read,
    input  logic             abort,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             hi_write,
    output logic             lo_write,
    output logic [WIDTH-1:0] hi_result,
    output logic [WIDTH-1:0] lo_result
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_e        state, state_next;
    md_op_e           op_q;
    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CNT_W-1:0] cnt;
    logic             neg_res, neg_rem;

    logic             is_div, is_sgn, a_neg, b_neg, div_zero, load_res;
    logic [WIDTH-1:0] a_abs, b_abs, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        is_div   = md_is_div(op_q);
        is_sgn   = md_is_signed(op_q);
        a_neg    = is_sgn & a_q[WIDTH-1];
        b_neg    = is_sgn & b_q[WIDTH-1];
        a_abs    = a_neg ? -a_q : a_q;
        b_abs    = b_neg ? -b_q : b_q;
        div_zero = is_div & (b_q == '0);
    end

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .hi      (acc_hi),
        .lo      (acc_lo),
        .m       (m_q),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (start) state_next = MD_PREP;
            MD_PREP: state_next = div_zero ? MD_DONE : MD_RUN;
            MD_RUN:  if (cnt == '0) state_next = MD_FIX;
            MD_FIX:  state_next = MD_DONE;
            MD_DONE: state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
        // flush beats everything, including a start arriving in IDLE
        if (abort) state_next = MD_IDLE;
    end

    always_comb begin
        busy     = (state != MD_IDLE);
        done     = (state == MD_DONE);
        hi_write = done;
        lo_write = done;
    end

    assign stall = busy & (start | hilo_read);

    always_comb begin
        prod   = {acc_hi[WIDTH-1:0], acc_lo};
        res_hi = '0;
        res_lo = '0;
        if (state == MD_PREP) begin
            res_hi = a_q;
            res_lo = '1;
        end else if (is_div) begin
            res_lo = neg_res ? -acc_lo : acc_lo;
            res_hi = neg_rem ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
        end else begin
            if (neg_res) prod = -prod;
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
        load_res = (state_next == MD_DONE) && (state != MD_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= MD_MULT;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            hi_result <= '0;
            lo_result <= '0;
        end else begin
            case (state)
                MD_IDLE: if (start && !abort) begin
                    op_q <= md_op_e'(op);
                    a_q  <= operand_a;
                    b_q  <= operand_b;
                end
                MD_PREP: begin
                    m_q     <= is_div ? b_abs : a_abs;
                    acc_hi  <= '0;
                    acc_lo  <= is_div ? a_abs : b_abs;
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    cnt     <= CNT_W'(WIDTH - 1);
                end
                MD_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
            if (load_res) begin
                hi_result <= res_hi;
                lo_result <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed, random and control-path cases.
module tb_muldiv_sequencer;
    import mips_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         hilo_read = 1'b0;
    logic         abort = 1'b0;
    logic         busy, stall, done, hi_write, lo_write;
    logic [W-1:0] hi_result, lo_result;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .hilo_read (hilo_read),
        .abort     (abort),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .hi_write  (hi_write),
        .lo_write  (lo_write),
        .hi_result (hi_result),
        .lo_result (lo_result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    res_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     edges = 0;
    int     e0 = 0;
    int     done_cyc = 0;
    int     write_cnt = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) edges++;

    // scoreboard: every HI/LO write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            res_t e;
            write_cnt++;
            done_cyc = edges - e0 + 1;
            check_val("wr_strobes", {62'd0, hi_write, lo_write}, 64'd3);
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("hi_result", hi_result, e.hi);
                check_val("lo_result", lo_result, e.lo);
                last_hi = e.hi;
                last_lo = e.lo;
            end
        end
    end

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ehi, input logic [W-1:0] elo, input bit push);
        res_t e;
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        if (push) begin
            e.hi = ehi; e.lo = elo;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        e0 = edges;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int wc0;
        wc0 = write_cnt;
        for (int i = 0; i < 100 && write_cnt == wc0; i++) begin
            @(negedge clk);
            #1;
        end
        check_val({tag, "_done_seen"}, 64'(write_cnt - wc0), 64'd1);
        check_val({tag, "_latency"}, 64'(done_cyc), 64'(exp_lat));
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input int lat);
        start_op(o, a, b, ehi, elo, 1'b1);
        wait_done(tag, lat);
    endtask

    task automatic run_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        longint      sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: p = 64'(sa * sb);
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: p = {32'(sa % sb), 32'(sa / sb)};
            default: p = {a % b, a / b};
        endcase
        run_op("rand", o, a, b, p[63:32], p[31:0], W + 3);
    endtask

    initial begin
        logic busy_ok;
        int   wc0;

        #12;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_wr", {62'd0, hi_write, lo_write}, 64'd0);
        check_val("rst_hi", hi_result, 64'd0);
        check_val("rst_lo", lo_result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // MULTU with stall / ignored-start / hilo_read probing
        start_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        busy_ok = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            start     = (c == 5);
            if (c == 5) begin
                op = MD_DIVU; operand_a = 32'd9; operand_b = 32'd0;
            end
            hilo_read = (c == 10 || c == 35 || c == 36);
            #1;
            if (c <= 35 && !busy) busy_ok = 1'b0;
            if (c == 5)  check_val("stall_start_c5", 64'(stall), 64'd1);
            if (c == 10) check_val("stall_read_c10", 64'(stall), 64'd1);
            if (c == 35) check_val("stall_read_c35", 64'(stall), 64'd1);
            if (c == 36) begin
                check_val("stall_read_c36", 64'(stall), 64'd0);
                check_val("busy_c36", 64'(busy), 64'd0);
                check_val("hold_hi_c36", hi_result, 64'hFFFF_FFFE);
                check_val("hold_lo_c36", lo_result, 64'h0000_0001);
            end
        end
        hilo_read = 1'b0;
        check_val("busy_1_35", 64'(busy_ok), 64'd1);
        check_val("multu_latency", 64'(done_cyc), 64'd35);
        check_val("ignored_start_writes", 64'(write_cnt), 64'd1);

        run_op("mult_neg",  MD_MULT, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 35);
        run_op("mult_min",  MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 35);
        run_op("div_neg",   MD_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35);
        run_op("div_negb",  MD_DIV, 32'd7, -32'sd2, 32'h1, 32'hFFFF_FFFD, 35);
        run_op("divu",      MD_DIVU, 32'd7, 32'd2, 32'h1, 32'h3, 35);
        run_op("div_ovf",   MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 35);
        run_op("divu_zero", MD_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 2);
        run_op("div_zero",  MD_DIV, -32'sd7, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 2);

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i >= 4 && rb == 0) rb = 32'd3;
            if (i >= 6) rb = rb >> $urandom_range(28, 16);
            if (rb == 0) rb = 32'd5;
            run_model(2'(i % 4), ra, rb);
        end

        // abort during RUN: back to IDLE, no write, results untouched
        start_op(MD_MULTU, 32'd5, 32'd6, '0, '0, 1'b0);
        wc0 = write_cnt;
        for (int c = 1; c <= 11; c++) @(negedge clk);
        abort = 1'b1;
        #1;
        check_val("abort_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        #1;
        check_val("abort_busy_after", 64'(busy), 64'd0);
        abort = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check_val("abort_no_write", 64'(write_cnt - wc0), 64'd0);
        check_val("abort_hold_hi", hi_result, last_hi);
        check_val("abort_hold_lo", lo_result, last_lo);

        // abort together with start in IDLE
        @(negedge clk);
        op = MD_MULTU; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        check_val("abort_start_busy", 64'(busy), 64'd0);

        // reset mid-RUN, then a normal operation afterwards
        start_op(MD_DIVU, 32'd1000, 32'd3, '0, '0, 1'b0);
        for (int c = 1; c <= 15; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_done", 64'(done), 64'd0);
        check_val("midrst_hi", hi_result, 64'd0);
        check_val("midrst_lo", lo_result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 35);

        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
